// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin CPU/DMA arbiter and sequencer for the SDRAM byte port.
module sdram_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TCNT_W         = 13
) (
  input  logic        clock_100_mhz,
  input  logic        reset_n,
  input  logic        c0_req,
  input  logic        c0_we,
  input  logic [25:0] c0_address,
  input  logic [7:0]  c0_wdata,
  output logic [7:0]  c0_rdata,
  output logic        c0_ack,
  input  logic        c1_req,
  input  logic        c1_we,
  input  logic [25:0] c1_address,
  input  logic [7:0]  c1_wdata,
  output logic [7:0]  c1_rdata,
  output logic        c1_ack,
  output logic [25:0] m_address,
  output logic        m_we,
  output logic [7:0]  m_wdata,
  input  logic [7:0]  m_rdata,
  input  logic        m_ready,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        timeout_err
);
  typedef enum logic [2:0] {
    IDLE, DUMMY_ISSUE, DUMMY_LOW, DUMMY_HIGH, ISSUE, W_LOW, W_HIGH, DONE
  } state_t;
  state_t      r_state, w_next;
  logic        r_rr_last, r_we;
  logic [25:0] r_addr, r_last_addr;
  logic [7:0]  r_wdata;
  logic [1:0]  r_grant;
  logic        w_any, w_pick1, w_abort;
  logic [25:0] w_sel_addr;
  assign w_any      = c0_req | c1_req;
  assign w_pick1    = c1_req & (~c0_req | ~r_rr_last);
  assign w_sel_addr = w_pick1 ? c1_address : c0_address;
`ifdef MEM_ARB_TIMEOUT_EN
  logic [TCNT_W-1:0] r_tcnt;
  logic              r_timeout_err;
  logic              w_wait, w_prog;
  assign w_wait  = r_state inside {DUMMY_LOW, DUMMY_HIGH, W_LOW, W_HIGH};
  assign w_prog  = (r_state inside {DUMMY_LOW, W_LOW}) ? ~m_ready : m_ready;
  assign w_abort = w_wait & ~w_prog & (r_tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clock_100_mhz or negedge reset_n)
    if (!reset_n) begin
      r_tcnt        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_tcnt        <= (w_next != r_state) ? '0 : r_tcnt + 1'b1;
      r_timeout_err <= r_timeout_err | w_abort;
    end
  assign timeout_err = r_timeout_err;
`else
  assign w_abort     = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_ff @(posedge clock_100_mhz or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:        w_next = !w_any ? IDLE : (w_sel_addr == r_last_addr) ? DUMMY_ISSUE : ISSUE;
      DUMMY_ISSUE: w_next = DUMMY_LOW;
      DUMMY_LOW:   w_next = !m_ready ? DUMMY_HIGH : w_abort ? DONE : DUMMY_LOW;
      DUMMY_HIGH:  w_next = m_ready ? ISSUE : w_abort ? DONE : DUMMY_HIGH;
      ISSUE:       w_next = W_LOW;
      W_LOW:       w_next = !m_ready ? W_HIGH : w_abort ? DONE : W_LOW;
      W_HIGH:      w_next = (m_ready | w_abort) ? DONE : W_HIGH;
      default:     w_next = IDLE;
    endcase
  end
  always_ff @(posedge clock_100_mhz or negedge reset_n)
    if (!reset_n) begin
      r_rr_last   <= 1'b1;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_last_addr <= '0;
      r_wdata     <= '0;
      r_grant     <= '0;
      m_address   <= '0;
      m_we        <= 1'b0;
      m_wdata     <= '0;
      c0_rdata    <= '0;
      c1_rdata    <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_grant   <= {w_pick1, ~w_pick1};
          r_rr_last <= w_pick1;
          r_we      <= w_pick1 ? c1_we : c0_we;
          r_addr    <= w_sel_addr;
          r_wdata   <= w_pick1 ? c1_wdata : c0_wdata;
        end
        DUMMY_ISSUE: begin
          m_address <= {r_addr[25:1], ~r_addr[0]};
          m_we      <= 1'b0;
        end
        ISSUE: begin
          m_address   <= r_addr;
          m_we        <= r_we;
          m_wdata     <= r_wdata;
          r_last_addr <= r_addr;
        end
        W_HIGH: if (m_ready && !r_we) begin
          if (r_grant[0]) c0_rdata <= m_rdata;
          else            c1_rdata <= m_rdata;
        end
        DONE: begin
          r_grant <= '0;
          m_we    <= 1'b0;
        end
        default: ;
      endcase
      if (w_abort) begin
        r_last_addr <= ~r_addr;
        if (r_grant[0]) c0_rdata <= 8'hFF;
        else            c1_rdata <= 8'hFF;
      end
    end
  assign grant  = r_grant;
  assign busy   = r_state != IDLE;
  assign c0_ack = (r_state == DONE) & r_grant[0];
  assign c1_ack = (r_state == DONE) & r_grant[1];
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed bench with a behavioural SDRAM byte-port model.
module tb_sdram_port_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        c0_req = 1'b0, c0_we = 1'b0, c1_req = 1'b0, c1_we = 1'b0;
  logic [25:0] c0_address = '0, c1_address = '0;
  logic [7:0]  c0_wdata = '0, c1_wdata = '0;
  logic [7:0]  c0_rdata, c1_rdata, m_wdata, m_rdata;
  logic        c0_ack, c1_ack, m_we, m_ready, busy, timeout_err;
  logic [25:0] m_address;
  logic [1:0]  grant;
  int          passed = 0, total = 0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.TIMEOUT_CYCLES(16), .TCNT_W(13)) dut (
    .clock_100_mhz(clk), .reset_n(rst_n),
    .c0_req(c0_req), .c0_we(c0_we), .c0_address(c0_address), .c0_wdata(c0_wdata),
    .c0_rdata(c0_rdata), .c0_ack(c0_ack),
    .c1_req(c1_req), .c1_we(c1_we), .c1_address(c1_address), .c1_wdata(c1_wdata),
    .c1_rdata(c1_rdata), .c1_ack(c1_ack),
    .m_address(m_address), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  logic [7:0]  mem [256];
  logic [25:0] mm_prev, mm_addr;
  logic        mm_we;
  logic [7:0]  mm_wd;
  int          mm_cnt;
  int          svc = 2;
  bit          stuck = 1'b0;
  logic [26:0] log_q [$];

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mm_prev <= '0;
      m_ready <= 1'b1;
      mm_cnt  <= 0;
      m_rdata <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else if (m_address != mm_prev) begin
      mm_prev <= m_address;
      mm_addr <= m_address;
      mm_we   <= m_we;
      mm_wd   <= m_wdata;
      log_q.push_back({m_we, m_address});
      if (!stuck) begin
        m_ready <= 1'b0;
        mm_cnt  <= svc;
      end
    end else if (!m_ready) begin
      if (mm_cnt == 0) begin
        m_ready <= 1'b1;
        if (mm_we) mem[mm_addr[7:0]] <= mm_wd;
        else       m_rdata <= mem[mm_addr[7:0]];
      end else mm_cnt <= mm_cnt - 1;
    end

  int ack0_n = 0, ack1_n = 0, both_n = 0;
  always @(negedge clk) begin
    if (c0_ack) ack0_n++;
    if (c1_ack) ack1_n++;
    if (c0_ack && c1_ack) both_n++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic do_reset;
    rst_n = 1'b0; c0_req = 1'b0; c1_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic txn(input bit p, input bit we, input logic [25:0] a, input logic [7:0] d,
                     output int cyc, output logic [7:0] rd);
    @(posedge clk); #1;
    if (!p) begin c0_req = 1'b1; c0_we = we; c0_address = a; c0_wdata = d; end
    else    begin c1_req = 1'b1; c1_we = we; c1_address = a; c1_wdata = d; end
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!(p ? c1_ack : c0_ack) && cyc < 1000);
    rd = p ? c1_rdata : c0_rdata;
    c0_req = 1'b0; c1_req = 1'b0;
    total++;
    if (cyc >= 1000) $display("FAIL ack_arrival: port %0d got no ack, required ack within 1000 cycles", p);
    else passed++;
  endtask

  task automatic test_reset;
    int a0;
    do_reset();
    total++;
    if ({grant, busy, m_we, c0_ack, c1_ack, timeout_err} !== 7'b0)
      $display("FAIL reset_outputs: got %b, required 0", {grant, busy, m_we, c0_ack, c1_ack, timeout_err});
    else passed++;
    total++;
    if ({m_address, m_wdata, c0_rdata, c1_rdata} !== 50'b0)
      $display("FAIL reset_data: got %h, required 0", {m_address, m_wdata, c0_rdata, c1_rdata});
    else passed++;
    a0 = ack0_n;
    @(posedge clk); #1;
    c0_req = 1'b1; c0_we = 1'b0; c0_address = 26'h33;
    repeat (4) @(negedge clk);
    rst_n = 1'b0; #1;
    total++;
    if ({busy, grant} !== 3'b0) $display("FAIL reset_async: busy/grant got %b, required 000", {busy, grant});
    else passed++;
    c0_req = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    total++;
    if (ack0_n - a0 !== 0) $display("FAIL reset_no_ack: got %0d acks, required 0", ack0_n - a0);
    else passed++;
  endtask

  task automatic test_write_no_dummy;
    int cyc, a0, a1;
    logic [7:0] rd;
    do_reset();
    log_q.delete();
    a0 = ack0_n; a1 = ack1_n;
    txn(0, 1, 26'h10, 8'hA5, cyc, rd);
    total++;
    if (cyc !== 8) $display("FAIL wr_latency: got %0d, required 8", cyc); else passed++;
    repeat (3) @(negedge clk);
    total++;
    if (log_q.size() !== 1 || log_q[0] !== {1'b1, 26'h10})
      $display("FAIL wr_mem_reqs: got size %0d first %h, required 1 x %h", log_q.size(), log_q[0], {1'b1, 26'h10});
    else passed++;
    total++;
    if (ack0_n - a0 !== 1 || ack1_n - a1 !== 0)
      $display("FAIL wr_acks: got c0 %0d c1 %0d, required 1 0", ack0_n - a0, ack1_n - a1);
    else passed++;
    total++;
    if (mem[8'h10] !== 8'hA5) $display("FAIL wr_data: got %h, required a5", mem[8'h10]); else passed++;
    total++;
    if ({m_address, m_we, busy, grant} !== {26'h10, 1'b0, 1'b0, 2'b00})
      $display("FAIL wr_after_done: got addr %h we %b busy %b grant %b, required 10 0 0 00", m_address, m_we, busy, grant);
    else passed++;
  endtask

  task automatic test_read_dummy;
    int cyc, a0;
    logic [7:0] rd;
    do_reset();
    log_q.delete();
    a0 = ack0_n;
    txn(0, 0, 26'h0, 8'h00, cyc, rd);
    total++;
    if (cyc !== 14) $display("FAIL rd0_latency: got %0d, required 14", cyc); else passed++;
    total++;
    if (rd !== 8'h5A) $display("FAIL rd0_data: got %h, required 5a", rd); else passed++;
    repeat (3) @(negedge clk);
    total++;
    if (log_q.size() !== 2 || log_q[0] !== {1'b0, 26'h1} || log_q[1] !== {1'b0, 26'h0})
      $display("FAIL rd0_mem_reqs: got size %0d %h %h, required 2 %h %h", log_q.size(), log_q[0], log_q[1],
               {1'b0, 26'h1}, {1'b0, 26'h0});
    else passed++;
    total++;
    if (ack0_n - a0 !== 1) $display("FAIL rd0_acks: got %0d, required 1", ack0_n - a0); else passed++;
  endtask

  task automatic test_back_to_back;
    int cyc, a1;
    logic [7:0] rd;
    log_q.delete();
    a1 = ack1_n;
    txn(1, 1, 26'h20, 8'h11, cyc, rd);
    total++;
    if (cyc !== 8) $display("FAIL b2b_first_latency: got %0d, required 8", cyc); else passed++;
    txn(1, 1, 26'h20, 8'h22, cyc, rd);
    total++;
    if (cyc !== 14) $display("FAIL b2b_second_latency: got %0d, required 14", cyc); else passed++;
    repeat (3) @(negedge clk);
    total++;
    if (log_q.size() !== 3 || log_q[1] !== {1'b0, 26'h21} || log_q[2] !== {1'b1, 26'h20})
      $display("FAIL b2b_mem_reqs: got size %0d %h %h, required 3 %h %h", log_q.size(), log_q[1], log_q[2],
               {1'b0, 26'h21}, {1'b1, 26'h20});
    else passed++;
    total++;
    if (ack1_n - a1 !== 2) $display("FAIL b2b_acks: got %0d, required 2", ack1_n - a1); else passed++;
    txn(0, 0, 26'h20, 8'h00, cyc, rd);
    total++;
    if (rd !== 8'h22 || cyc !== 14) $display("FAIL b2b_readback: got %h after %0d, required 22 after 14", rd, cyc);
    else passed++;
  endtask

  task automatic test_round_robin;
    int cyc, b0;
    logic [1:0] exp;
    do_reset();
    log_q.delete();
    b0 = both_n;
    @(posedge clk); #1;
    c0_req = 1'b1; c0_we = 1'b0; c0_address = 26'h40;
    c1_req = 1'b1; c1_we = 1'b0; c1_address = 26'h41;
    for (int k = 0; k < 4; k++) begin
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!(c0_ack || c1_ack) && cyc < 100);
      total++;
      if ({c1_ack, c0_ack} !== exp || grant !== exp)
        $display("FAIL rr_order[%0d]: ack %b grant %b, required %b", k, {c1_ack, c0_ack}, grant, exp);
      else passed++;
      total++;
      if ((exp[0] ? c0_rdata : c1_rdata) !== (exp[0] ? 8'h1A : 8'h1B))
        $display("FAIL rr_data[%0d]: got %h, required %h", k, exp[0] ? c0_rdata : c1_rdata, exp[0] ? 8'h1A : 8'h1B);
      else passed++;
    end
    c0_req = 1'b0; c1_req = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (both_n - b0 !== 0 || log_q.size() !== 4)
      $display("FAIL rr_overlap: dual acks %0d mem reqs %0d, required 0 and 4", both_n - b0, log_q.size());
    else passed++;
  endtask

  task automatic test_long_stall;
    int cyc, viol;
    bit have;
    logic [34:0] ref_v;
    svc = 300;
    @(posedge clk); #1;
    c0_req = 1'b1; c0_we = 1'b1; c0_address = 26'h80; c0_wdata = 8'h77;
    cyc = 0; have = 1'b0; viol = 0; ref_v = '0;
    do begin
      @(negedge clk); cyc++;
      if (have && {m_we, m_wdata, m_address} !== ref_v) viol++;
      if (!have && m_address == 26'h80) begin have = 1'b1; ref_v = {m_we, m_wdata, m_address}; end
    end while (!c0_ack && cyc < 1000);
    c0_req = 1'b0;
    svc = 2;
    total++;
    if (cyc !== 306) $display("FAIL stall_latency: got %0d, required 306", cyc); else passed++;
    total++;
    if (!have || viol !== 0 || ref_v !== {1'b1, 8'h77, 26'h80})
      $display("FAIL stall_stable: seen %b changes %0d issued %h, required 1 0 %h", have, viol, ref_v,
               {1'b1, 8'h77, 26'h80});
    else passed++;
    @(negedge clk);
    total++;
    if (mem[8'h80] !== 8'h77) $display("FAIL stall_data: got %h, required 77", mem[8'h80]); else passed++;
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout;
    int cyc;
    logic [7:0] rd;
    stuck = 1'b1;
    txn(0, 0, 26'h100, 8'h00, cyc, rd);
    total++;
    if (cyc !== 19) $display("FAIL to_latency: got %0d, required 19", cyc); else passed++;
    total++;
    if (rd !== 8'hFF) $display("FAIL to_rdata: got %h, required ff", rd); else passed++;
    repeat (3) @(negedge clk);
    total++;
    if (timeout_err !== 1'b1 || busy !== 1'b0)
      $display("FAIL to_flag: err %b busy %b, required 1 0", timeout_err, busy);
    else passed++;
    stuck = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_write_no_dummy();
    test_read_dummy();
    test_back_to_back();
    test_round_robin();
    test_long_stall();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
